// File: rtl/mm_pkg.sv
// Shared types and helpers for the result-matrix output buffer.
package mm_pkg;

    localparam int OUTW_DEFAULT = 28;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } out_state_t;

endpackage

// File: rtl/output_mems_chk.sv
// Simulation checker: the issue throttle must never let the skid FIFO overflow.
module out_skid_fifo_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/output_mems_ram.sv
// Single-port RAM: write on wr_en, synchronous read with one cycle of latency.
module mm_ram #(
    parameter int W     = 28,
    parameter int DEPTH = 63,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    // Storage write and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
        r_rd_data <= r_mem[addr];
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/output_mems_skid_fifo.sv
// Two-entry output FIFO; head data, last tag and valid are all flop outputs.
module out_skid_fifo #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         full,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [1:0]   r_count;
    logic [1:0]   w_count_nxt;
    logic         r_valid;
    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic         r_l0;
    logic         r_l1;

    // Occupancy update for every push/pop combination.
    always_comb begin
        w_count_nxt = r_count;
        case ({push, pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry storage; entry 0 is always the head presented downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
            r_d0    <= '0;
            r_d1    <= '0;
            r_l0    <= 1'b0;
            r_l1    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_d0 <= push_data;
                        r_l0 <= push_last;
                    end else begin
                        r_d1 <= push_data;
                        r_l1 <= push_last;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                    end else begin
                        r_l0 <= 1'b0;
                    end
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_d0 <= push_data;
                        r_l0 <= push_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= push_data;
                        r_l1 <= push_last;
                    end
                end
                default: begin
                    r_d0 <= r_d0;
                end
            endcase
        end
    end

    assign count      = r_count;
    assign full       = (r_count == 2'd2);
    assign head_valid = r_valid;
    assign head_data  = r_d0;
    assign head_last  = r_l0;

endmodule

// File: rtl/output_mems.sv
// Result matrix buffer: collects C from compute, then streams it row-major over AXI-Stream.
module output_mems
    import mm_pkg::*;
#(
    parameter int OUTW = OUTW_DEFAULT,
    parameter int M    = 7,
    parameter int N    = 9
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            C_wr_en,
    input  logic [addr_bits(M*N)-1:0]       C_wr_addr,
    input  logic [OUTW-1:0]                 C_wr_data,
    input  logic                            compute_done,
    output logic                            output_ready,
    output logic [OUTW-1:0]                 AXIS_TDATA,
    output logic                            AXIS_TVALID,
    output logic                            AXIS_TLAST,
    input  logic                            AXIS_TREADY
);

    localparam int DEPTH       = M * N;
    localparam int C_ADDR_BITS = addr_bits(DEPTH);
    localparam int PTRW        = C_ADDR_BITS + 1;
    localparam logic [PTRW-1:0] LAST_ADDR = PTRW'(DEPTH - 1);

    out_state_t             r_state;
    out_state_t             w_state_nxt;
    logic [PTRW-1:0]        r_rd_ptr;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic                   r_output_ready;
    logic                   w_pop;
    logic                   w_issue;
    logic                   w_last_hs;
    logic [2:0]             w_occupancy;
    logic                   w_ram_we;
    logic [C_ADDR_BITS-1:0] w_ram_addr;
    logic [OUTW-1:0]        w_ram_rdata;
    logic [1:0]             w_fifo_count;
    logic                   w_fifo_full;

    // Issue throttle counts the read in flight so a returning word always has a free slot.
    always_comb begin
        w_pop       = AXIS_TVALID & AXIS_TREADY;
        w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = (r_state == STREAM) && (r_rd_ptr <= LAST_ADDR) && (w_occupancy < 3'd2);
        w_last_hs   = w_pop & AXIS_TLAST;
        w_ram_we    = (r_state == LOAD) & C_wr_en;
        if (r_state == LOAD) begin
            w_ram_addr = C_wr_addr;
        end else begin
            w_ram_addr = r_rd_ptr[C_ADDR_BITS-1:0];
        end
    end

    // Next-state logic: done starts a stream, the TLAST handshake ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (compute_done) begin
                    w_state_nxt = STREAM;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            STREAM: begin
                if (w_last_hs) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // State, read pointer and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= LOAD;
            r_output_ready  <= 1'b1;
            r_rd_ptr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_output_ready  <= (w_state_nxt == LOAD);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_ptr == LAST_ADDR);
            if (w_state_nxt == LOAD) begin
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    mm_ram #(
        .W     (OUTW),
        .DEPTH (DEPTH),
        .AW    (C_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_ram_we),
        .addr    (w_ram_addr),
        .wr_data (C_wr_data),
        .rd_data (w_ram_rdata)
    );

    out_skid_fifo #(
        .W (OUTW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (r_inflight),
        .push_data  (w_ram_rdata),
        .push_last  (r_inflight_last),
        .pop        (w_pop),
        .count      (w_fifo_count),
        .full       (w_fifo_full),
        .head_valid (AXIS_TVALID),
        .head_data  (AXIS_TDATA),
        .head_last  (AXIS_TLAST)
    );

    out_skid_fifo_chk u_fifo_chk (
        .clk   (clk),
        .reset (reset),
        .push  (r_inflight),
        .full  (w_fifo_full)
    );

    assign output_ready = r_output_ready;

endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems: scenario table plus hand sequences, checked against an array model of C.
module tb_output_mems;

    localparam int W  = 28;
    localparam int M  = 7;
    localparam int N  = 9;
    localparam int MN = M * N;
    localparam int AW = 6;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          C_wr_en;
    logic [AW-1:0] C_wr_addr;
    logic [W-1:0]  C_wr_data;
    logic          compute_done;
    logic          output_ready;
    logic [W-1:0]  AXIS_TDATA;
    logic          AXIS_TVALID;
    logic          AXIS_TLAST;
    logic          AXIS_TREADY;

    always #5 clk = ~clk;

    output_mems #(.OUTW(W), .M(M), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .C_wr_en      (C_wr_en),
        .C_wr_addr    (C_wr_addr),
        .C_wr_data    (C_wr_data),
        .compute_done (compute_done),
        .output_ready (output_ready),
        .AXIS_TDATA   (AXIS_TDATA),
        .AXIS_TVALID  (AXIS_TVALID),
        .AXIS_TLAST   (AXIS_TLAST),
        .AXIS_TREADY  (AXIS_TREADY)
    );

    typedef struct {
        int         pat;
        int         mode;
        bit         chk_lat;
        bit         chk_ends;
        logic [W-1:0] first;
        logic [W-1:0] last;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] model_mem [MN];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    int           first_valid;
    int           last_cyc;
    vec_t         tbl [5];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        C_wr_en   = 1'b1;
        C_wr_addr = AW'(a);
        C_wr_data = d;
        model_mem[a] = d;
        @(posedge clk); #1;
        C_wr_en = 1'b0;
    endtask

    task automatic load_pattern(input int pat);
        case (pat)
            0: for (int i = 0; i < MN; i++) wr(i, W'(i + 100));
            1: begin
                for (int i = MN - 1; i >= 0; i--) wr(i, W'(-i));
                wr(5, W'(7));
                wr(5, W'(-3));
            end
            2: for (int i = 0; i < MN; i++) wr(i, W'(2 * i));
            default: begin
                for (int i = 0; i < MN; i++) wr(i, W'($urandom));
                for (int k = 0; k < 20; k++) wr($urandom_range(0, MN - 1), W'($urandom));
            end
        endcase
    endtask

    task automatic do_done(input bit with_wr, input int a, input logic [W-1:0] d);
        compute_done = 1'b1;
        if (with_wr) begin
            C_wr_en   = 1'b1;
            C_wr_addr = AW'(a);
            C_wr_data = d;
            model_mem[a] = d;
        end
        @(posedge clk); #1;
        compute_done = 1'b0;
        C_wr_en      = 1'b0;
        exp_q.delete();
        for (int i = 0; i < MN; i++) exp_q.push_back(model_mem[i]);
        chk("ready_drop", W'(output_ready), W'(0));
    endtask

    // Runs one stream from just after the done edge; stop_after>0 ends early after that many beats.
    task automatic stream(input int mode, input bit inject, input int stop_after, output bit ended);
        int           cyc = 0;
        int           stall = 0;
        bit           prev_stall = 1'b0;
        logic [W-1:0] prev_d = '0;
        bit           prev_l = 1'b0;
        bit           hs;
        ended = 1'b0;
        got_d.delete();
        got_l.delete();
        first_valid = -1;
        last_cyc = -1;
        while (cyc < LIMIT) begin
            if (mode == 0) AXIS_TREADY = 1'b1;
            else if (got_d.size() < 10) AXIS_TREADY = 1'b1;
            else if (stall < 5) begin
                AXIS_TREADY = 1'b0;
                stall++;
            end else AXIS_TREADY = 1'($urandom_range(0, 1));
            C_wr_en      = inject && (cyc == 20);
            compute_done = inject && (cyc == 20);
            C_wr_addr    = '0;
            C_wr_data    = W'(999);
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_valid", W'(AXIS_TVALID), W'(1));
                chk("hold_data", AXIS_TDATA, prev_d);
                chk("hold_last", W'(AXIS_TLAST), W'(prev_l));
            end
            if (AXIS_TVALID && first_valid < 0) first_valid = cyc;
            hs = AXIS_TVALID && AXIS_TREADY;
            if (hs) begin
                got_d.push_back(AXIS_TDATA);
                got_l.push_back(AXIS_TLAST);
                last_cyc = cyc;
            end
            prev_stall = AXIS_TVALID && !AXIS_TREADY;
            prev_d     = AXIS_TDATA;
            prev_l     = AXIS_TLAST;
            @(posedge clk); #1;
            cyc++;
            if (hs && got_l[got_l.size() - 1]) begin
                ended = 1'b1;
                break;
            end
            if (stop_after > 0 && got_d.size() == stop_after) break;
        end
        C_wr_en      = 1'b0;
        compute_done = 1'b0;
        AXIS_TREADY  = 1'b0;
        if (cyc >= LIMIT) chk("stream_timeout", W'(cyc), W'(0));
    endtask

    task automatic check_stream();
        chk("beat_count", W'(got_d.size()), W'(MN));
        for (int i = 0; i < got_d.size() && i < MN; i++) begin
            chk($sformatf("data[%0d]", i), got_d[i], exp_q[i]);
            chk($sformatf("last[%0d]", i), W'(got_l[i]), W'(i == MN - 1));
        end
    endtask

    task automatic check_after_end(input bit ended);
        chk("stream_ended", W'(ended), W'(1));
        chk("ready_back", W'(output_ready), W'(1));
        chk("valid_drop", W'(AXIS_TVALID), W'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ended;
        int nlast;
        tbl[0] = '{0, 0, 1'b1, 1'b1, W'(100), W'(162)};
        tbl[1] = '{0, 1, 1'b0, 1'b1, W'(100), W'(162)};
        tbl[2] = '{1, 0, 1'b1, 1'b1, W'(0),   W'(-62)};
        tbl[3] = '{2, 1, 1'b0, 1'b1, W'(0),   W'(124)};
        tbl[4] = '{3, 1, 1'b0, 1'b0, W'(0),   W'(0)};

        reset = 1'b1; C_wr_en = 1'b0; C_wr_addr = '0; C_wr_data = '0;
        compute_done = 1'b0; AXIS_TREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", W'(output_ready), W'(1));
        chk("rst_valid", W'(AXIS_TVALID), W'(0));
        chk("rst_last", W'(AXIS_TLAST), W'(0));
        chk("rst_data", AXIS_TDATA, W'(0));
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            load_pattern(tbl[t].pat);
            do_done(1'b0, 0, W'(0));
            stream(tbl[t].mode, 1'b0, 0, ended);
            check_after_end(ended);
            check_stream();
            if (tbl[t].chk_ends && got_d.size() == MN) begin
                chk("first_beat", got_d[0], tbl[t].first);
                chk("last_beat", got_d[MN - 1], tbl[t].last);
            end
            if (tbl[t].chk_lat) begin
                chk("first_valid_lat", W'(first_valid), W'(2));
                chk("back_to_back", W'(last_cyc - first_valid + 1), W'(MN));
            end
            if (tbl[t].pat == 1 && got_d.size() > 5) chk("beat5_overwrite", got_d[5], W'(-3));
        end

        // Writes and done pulses during STREAM must be ignored.
        do_done(1'b0, 0, W'(0));
        stream(0, 1'b1, 0, ended);
        check_after_end(ended);
        check_stream();
        repeat (3) begin
            @(negedge clk);
            chk("no_restart", W'(AXIS_TVALID), W'(0));
        end
        @(posedge clk); #1;
        do_done(1'b0, 0, W'(0));
        stream(0, 1'b0, 0, ended);
        check_after_end(ended);
        check_stream();
        if (got_d.size() > 0) chk("addr0_kept", got_d[0], model_mem[0]);

        // Final write in the same cycle as compute_done.
        load_pattern(0);
        do_done(1'b1, MN - 1, W'(42));
        stream(1, 1'b0, 0, ended);
        check_after_end(ended);
        check_stream();
        if (got_d.size() == MN) chk("same_cycle_last", got_d[MN - 1], W'(42));

        // Reset after 10 beats, then a fresh matrix.
        load_pattern(0);
        do_done(1'b0, 0, W'(0));
        stream(0, 1'b0, 10, ended);
        nlast = 0;
        foreach (got_l[i]) nlast += int'(got_l[i]);
        chk("partial_beats", W'(got_d.size()), W'(10));
        chk("partial_no_last", W'(nlast), W'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_valid", W'(AXIS_TVALID), W'(0));
        chk("midrst_ready", W'(output_ready), W'(1));
        load_pattern(2);
        do_done(1'b0, 0, W'(0));
        stream(0, 1'b0, 0, ended);
        check_after_end(ended);
        check_stream();
        if (got_d.size() == MN) begin
            chk("rst_first", got_d[0], W'(0));
            chk("rst_last_beat", got_d[MN - 1], W'(124));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_mems.md
Name: output_mems

Overview:
- Result-side counterpart of the matrix input loader. Buffers the M x N result matrix C written by the compute datapath, then streams it out as an AXI-Stream master, row-major, with TLAST on the final element.
- Sits between the MAC/compute array and the top-level output AXIS port.
- Gives compute an output_ready flag so it does not overwrite C while C is being streamed.

Parameters:
- OUTW, 28, width of one C element (signed, two's complement)
- M, 7, rows of C
- N, 9, columns of C
- C_ADDR_BITS (localparam), $clog2(M*N), C address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- C_wr_en  in  1  compute writes C_wr_data to C_wr_addr this cycle
- C_wr_addr  in  C_ADDR_BITS  element index, row*N + col
- C_wr_data  in  OUTW  signed result element
- compute_done  in  1  single-cycle pulse: all of C has been written
- output_ready  out  1  high while block accepts C writes (LOAD state)
- AXIS_TDATA  out  OUTW  streamed element
- AXIS_TVALID  out  1  master valid
- AXIS_TLAST  out  1  high with element M*N-1
- AXIS_TREADY  in  1  downstream ready

Behaviour:
- Storage: one M*N x OUTW single-port RAM. Use the team's memory module: synchronous read with 1-cycle latency, write on wr_en. Address mux is wr_addr in LOAD and rd_ptr in STREAM.
- Reset values:
  - state = LOAD
  - output_ready = 1
  - AXIS_TVALID = 0, AXIS_TLAST = 0, AXIS_TDATA = 0
  - rd_ptr = 0, FIFO empty, read-in-flight flag = 0
  - RAM contents are not reset.
- LOAD:
  - C_wr_en writes RAM. Writes may arrive in any order; the last write to an address wins.
  - compute_done sampled high moves the FSM to STREAM next cycle and drops output_ready that same edge.
  - A C_wr_en and compute_done in the same cycle: the write is committed and that value is streamed.
- STREAM:
  - C_wr_en and compute_done are ignored; no RAM write occurs.
  - Read issue condition: rd_ptr <= M*N-1 AND (fifo_count + inflight - pop) < 2, where pop = TVALID & TREADY this cycle.
  - On issue: drive RAM addr = rd_ptr, set inflight, increment rd_ptr.
  - Data returns next cycle and is pushed into the 2-entry output FIFO (skid buffer), tagged last = (addr == M*N-1).
  - AXIS_TVALID = FIFO non-empty. TDATA/TLAST come from the FIFO head, registered, so the FIFO outputs are flops.
  - Full throughput: with TREADY held high, one beat per cycle.
  - First TVALID is asserted 2 cycles after the edge that sampled compute_done.
  - Once TVALID is high, TDATA/TLAST hold stable and TVALID stays high until a handshake. TVALID never depends combinationally on TREADY.
  - Handshake on the beat with TLAST moves the FSM to LOAD next cycle: output_ready = 1, rd_ptr = 0, TVALID = 0. No beat is dropped or duplicated.
- FIFO boundaries:
  - Push and pop in the same cycle with count 1 or 2: count unchanged.
  - Push when full cannot occur, guaranteed by the issue condition. Assert on it in simulation.
- Reset mid-STREAM: FSM to LOAD, FIFO flushed, TVALID low on the next cycle. The partially sent matrix is abandoned; downstream sees no TLAST.
- Width: rd_ptr has C_ADDR_BITS+1 bits so the compare against M*N does not wrap when M*N is a power of two.

Decomposition:
- Package mm_pkg:
  - OUTW default
  - clog2-based address-width helper
  - enum type out_state_t {LOAD, STREAM}
- Sub-module out_skid_fifo: a 2-entry FIFO with push/pop/count, data + last tag, and registered head outputs.
- RAM: the existing memory module.
- Top holds the FSM, rd_ptr, inflight flag and address mux.

Test Plan:
- Stream with no backpressure:
  - Stimulus: write C[i] = i+100 for i = 0..62 in order, pulse compute_done, hold TREADY = 1.
  - Expected: 63 back-to-back beats with data 100..162; TLAST only on beat 63; first TVALID 2 cycles after the done edge; output_ready = 1 the cycle after the last beat.
- Backpressure:
  - Stimulus: same load; TREADY low for 5 cycles after beat 10, then a random 50% TREADY pattern.
  - Expected: TDATA/TLAST stable while stalled; sequence still exactly 100..162 with no gaps or repeats.
- Write order and signedness:
  - Stimulus: write addresses in reverse order with negative values, C[i] = -i; then write C[5] twice, first 7 then -3.
  - Expected: stream is 0, -1, -2, ...; beat 5 = -3; sign bits intact at OUTW width.
- Ignored inputs during STREAM:
  - Stimulus: during STREAM assert C_wr_en to addr 0 with 999, and pulse compute_done again.
  - Expected: streamed data unchanged, no restart; the next LOAD sees the old value at addr 0.
- Same-cycle final write:
  - Stimulus: final write C[62] = 42 in the same cycle as compute_done.
  - Expected: last beat = 42 with TLAST.
- Reset mid-stream:
  - Stimulus: reset after 10 beats, then a fresh load of C[i] = 2i and compute_done.
  - Expected: TVALID = 0 the cycle after reset, output_ready = 1; the new stream starts at 0 and runs to 124 with correct TLAST.
